stopwatch_ctrl: RTL

Mode controller that sequences the stopwatch digit counter. Converts debounced button levels into registered control for the counter: a one-cycle seconds tick, pause, counter clear, and the digit-adjust select/value pair. Sits between the button debouncers and the counter; the display driver takes the blink output.

---
 rtl/stopwatch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: button edges -> tick / pause / clear / digit-adjust control.
// Optional blink divider enabled with `define STOPWATCH_BLINK_EN.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       btn_adj,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic [4:0] cur_min_l,
  input  logic [4:0] cur_min_r,
  input  logic [4:0] cur_sec_l,
  input  logic [4:0] cur_sec_r,
  output logic       tick,
  output logic       paused,
  output logic       cnt_clr,
  output logic [2:0] adj_sel,
  output logic [4:0] adj_val,
  output logic       blink
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StRun, StPause, StAdj} state_e;

  state_e        state_q, state_d;
  logic [4:0]    btn, btn_prev_q, edge_q;
  logic          e_clr, e_adj, e_pause, e_sel, e_inc;
  logic [2:0]    sel_d;
  logic [4:0]    val_d, ld_val, lim;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_d;

  // Bit order matches the priority order: clr, adj, pause, sel, inc.
  assign btn     = {btn_inc, btn_sel, btn_pause, btn_adj, btn_clr};
  assign e_clr   = edge_q[0];
  assign e_adj   = edge_q[1];
  assign e_pause = edge_q[2];
  assign e_sel   = edge_q[3];
  assign e_inc   = edge_q[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_prev_q <= '0;
      edge_q     <= '0;
    end else begin
      btn_prev_q <= btn;
      edge_q     <= btn & ~btn_prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = adj_sel;
    val_d   = adj_val;
    ld_val  = cur_min_l;
    lim     = 5'd9;
    if (e_clr) val_d = '0;
    if (e_adj) begin
      if (state_q == StAdj) begin
        state_d = StPause;
        sel_d   = 3'd4;
      end else begin
        state_d = StAdj;
        sel_d   = 3'd0;
        val_d   = cur_min_l;
      end
    end else if (e_pause) begin
      if (state_q == StRun) begin
        state_d = StPause;
      end else if (state_q == StPause) begin
        state_d = StRun;
      end else begin
        state_d = StPause;
        sel_d   = 3'd4;
      end
    end else if (state_q == StAdj) begin
      if (e_sel) begin
        sel_d = (adj_sel == 3'd3) ? 3'd0 : adj_sel + 3'd1;
        case (sel_d)
          3'd1:    ld_val = cur_min_r;
          3'd2:    ld_val = cur_sec_l;
          3'd3:    ld_val = cur_sec_r;
          default: ld_val = cur_min_l;
        endcase
        val_d = ld_val;
      end
      // Inc sees the value after any same-cycle select load; >= also catches out-of-range loads.
      if (e_inc) begin
        lim   = (sel_d == 3'd2) ? 5'd5 : 5'd9;
        val_d = (val_d >= lim) ? 5'd0 : val_d + 5'd1;
      end
    end
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    if (e_clr) begin
      tick_cnt_d = '0;
    end else if (state_q == StRun) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StPause;
      tick_cnt_q <= '0;
      tick       <= 1'b0;
      paused     <= 1'b1;
      cnt_clr    <= 1'b0;
      adj_sel    <= 3'd4;
      adj_val    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tick       <= tick_d;
      paused     <= (state_d != StRun);
      cnt_clr    <= e_clr;
      adj_sel    <= sel_d;
      adj_val    <= val_d;
    end
  end

`ifdef STOPWATCH_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q, blink_ph_d, blink_wrap;

  assign blink_wrap = (blink_cnt_q == BLINK_LAST);
  assign blink_ph_d = blink_wrap ? ~blink_ph_q : blink_ph_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      blink       <= 1'b0;
    end else begin
      blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BW'(1);
      blink_ph_q  <= blink_ph_d;
      blink       <= (state_d == StAdj) & blink_ph_d;
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule
